ba_resp_body_builder: RTL

- TX-side consumer of the BA controller's PS Bitmap byte stream.
- Assembles the body of a compressed BlockAck response as a byte stream for the TX frame formatter, which appends FCS:
  - BA Control (2 bytes), then
  - BA SSN Control plus bitmap (BITMAP_BYTES bytes, pulled from the BA controller).
- Drives the psBitmapReady request and guards against a stalled bitmap source with a timeout.

---
 rtl/ba_resp_body_builder_pkg.sv | 41 ++++
 rtl/ba_resp_body_builder_if.sv | 40 ++++
 rtl/ba_resp_body_builder_out_reg.sv | 50 +++++
 rtl/ba_resp_body_builder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ba_resp_body_builder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ba_resp_pkg
// Description : Shared types and BA Control field positions for the
//               compressed BlockAck response body builder.
// Revision    : 1.0 - initial release
// ============================================================================
package ba_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CTRL0  = 2'd1,
        CTRL1  = 2'd2,
        BITMAP = 2'd3
    } ba_state_e;

    // Bit positions inside the 16-bit BA Control field
    localparam int ACK_POLICY = 0;
    localparam int MULTI_TID  = 1;
    localparam int COMPRESSED = 2;
    localparam int TID_LSB    = 12;

    localparam int BA_CTRL_BYTES = 2;
    // Body length for the default 10-byte SSN Control + bitmap section
    localparam int BA_BODY_LEN   = BA_CTRL_BYTES + 10;

    // One byte of the BA Control field: hi=0 gives bits 7:0, hi=1 bits 15:8
    function automatic logic [7:0] ba_ctrl_byte(input logic [3:0] tid,
                                                input logic       ack,
                                                input logic       hi);
        logic [15:0] w_word;
        w_word                 = '0;
        w_word[ACK_POLICY]     = ack;
        w_word[MULTI_TID]      = 1'b0;
        w_word[COMPRESSED]     = 1'b1;
        w_word[TID_LSB +: 4]   = tid;
        return hi ? w_word[15:8] : w_word[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ba_resp_body_builder_if.sv
`default_nettype none
// ============================================================================
// Module      : ba_resp_body_builder_if
// Description : Control, bitmap-source and TX byte-stream signals of the
//               BA response body builder.
// Revision    : 1.0 - initial release
// ============================================================================
interface ba_resp_body_builder_if;
    logic       startBA_p;
    logic [3:0] baTID;
    logic       baAckPolicy;
    logic       abort_p;
    logic [7:0] psBitmap;
    logic       psBitmapValid;
    logic       psBitmapReady;
    logic [7:0] txByte;
    logic       txByteValid;
    logic       txByteLast;
    logic       txByteReady;
    logic       baBodyDone_p;
    logic       baBodyError_p;
    logic       busy;

    // Builder side
    modport slave (
        input  startBA_p, baTID, baAckPolicy, abort_p,
        input  psBitmap, psBitmapValid, txByteReady,
        output psBitmapReady, txByte, txByteValid, txByteLast,
        output baBodyDone_p, baBodyError_p, busy
    );

    // Environment side (BA controller, TX formatter, sequencer)
    modport master (
        output startBA_p, baTID, baAckPolicy, abort_p,
        output psBitmap, psBitmapValid, txByteReady,
        input  psBitmapReady, txByte, txByteValid, txByteLast,
        input  baBodyDone_p, baBodyError_p, busy
    );
endinterface
`default_nettype wire

// File: rtl/ba_resp_body_builder_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : ba_resp_out_reg
// Description : One-entry valid/ready output register with load, hold and
//               flush. Load takes priority over a same-cycle accept so the
//               stream can run at one byte per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ba_resp_out_reg (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_load,
    input  wire logic [7:0] i_data,
    input  wire logic       i_last,
    input  wire logic       i_flush,
    input  wire logic       i_ready,
    output logic            o_valid,
    output logic [7:0]      o_data,
    output logic            o_last
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last;

    // Flush > load > drain-on-accept; data is held while valid and not accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/ba_resp_body_builder.sv
`default_nettype none
// ============================================================================
// Module      : ba_resp_body_builder
// Description : Builds the compressed BlockAck response body (BA Control,
//               then SSN Control + bitmap pulled from the BA controller) as
//               a valid/ready byte stream, with a stalled-source timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ba_resp_body_builder
    import ba_resp_pkg::*;
#(
    parameter int BITMAP_BYTES = 10,
    parameter int TIMEOUT      = 64
) (
    input  wire logic             macCoreClk,
    input  wire logic             macCoreClkRst,
    ba_resp_body_builder_if.slave bus
);

    localparam logic [3:0] C_BB      = 4'(BITMAP_BYTES);
    localparam logic [3:0] C_BB_LAST = 4'(BITMAP_BYTES - 1);
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

    ba_state_e  r_state, w_next_state;
    logic [3:0] r_tid;
    logic       r_ack;
    logic [3:0] r_byte_cnt, w_byte_cnt_next;
    logic [7:0] r_to_cnt, w_to_cnt_next;
    logic       r_done, r_error;
    logic       w_done_set, w_error_set, w_latch;
    logic       w_load, w_load_last, w_flush, w_ps_ready;
    logic [7:0] w_load_data;
    logic       w_out_valid, w_out_last;
    logic [7:0] w_out_data;
    logic       w_accept, w_room, w_all_loaded, w_last_accept;

    assign w_accept      = w_out_valid & bus.txByteReady;
    assign w_room        = ~w_out_valid | bus.txByteReady;
    assign w_all_loaded  = (r_byte_cnt == C_BB);
    assign w_last_accept = w_accept & w_out_last;

    ba_resp_out_reg u_out_reg (
        .clk     (macCoreClk),
        .rst     (macCoreClkRst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_last  (w_load_last),
        .i_flush (w_flush),
        .i_ready (bus.txByteReady),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_last  (w_out_last)
    );

    // State, latched header fields, counters and registered status pulses
    always_ff @(posedge macCoreClk) begin
        if (macCoreClkRst) begin
            r_state    <= IDLE;
            r_tid      <= 4'h0;
            r_ack      <= 1'b0;
            r_byte_cnt <= 4'h0;
            r_to_cnt   <= 8'h00;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            if (w_latch) begin
                r_tid <= bus.baTID;
                r_ack <= bus.baAckPolicy;
            end
            r_byte_cnt <= w_byte_cnt_next;
            r_to_cnt   <= w_to_cnt_next;
            r_done     <= w_done_set;
            r_error    <= w_error_set;
        end
    end

    // Next-state, output-register control and bitmap request
    always_comb begin
        w_next_state    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_to_cnt_next   = r_to_cnt;
        w_latch         = 1'b0;
        w_load          = 1'b0;
        w_load_data     = 8'h00;
        w_load_last     = 1'b0;
        w_flush         = 1'b0;
        w_ps_ready      = 1'b0;
        w_done_set      = 1'b0;
        w_error_set     = 1'b0;

        case (r_state)
            IDLE: begin
                w_byte_cnt_next = 4'h0;
                w_to_cnt_next   = 8'h00;
                // First header byte is loaded straight from the inputs so it
                // is valid one cycle after the start pulse.
                if (bus.startBA_p && !bus.abort_p) begin
                    w_latch      = 1'b1;
                    w_load       = 1'b1;
                    w_load_data  = ba_ctrl_byte(bus.baTID, bus.baAckPolicy, 1'b0);
                    w_next_state = CTRL0;
                end
            end
            CTRL0: begin
                if (bus.abort_p) begin
                    w_flush      = 1'b1;
                    w_next_state = IDLE;
                end else if (w_accept) begin
                    w_load       = 1'b1;
                    w_load_data  = ba_ctrl_byte(r_tid, r_ack, 1'b1);
                    w_next_state = CTRL1;
                end
            end
            CTRL1: begin
                if (bus.abort_p) begin
                    w_flush      = 1'b1;
                    w_next_state = IDLE;
                end else if (w_accept) begin
                    // Request the first bitmap byte while the second header
                    // byte leaves, so the body has no bubble at the seam.
                    w_ps_ready      = 1'b1;
                    w_next_state    = BITMAP;
                    w_byte_cnt_next = 4'h0;
                    w_to_cnt_next   = 8'h00;
                    if (bus.psBitmapValid) begin
                        w_load          = 1'b1;
                        w_load_data     = bus.psBitmap;
                        w_load_last     = (C_BB_LAST == 4'h0);
                        w_byte_cnt_next = 4'h1;
                    end
                end
            end
            BITMAP: begin
                if (w_last_accept) begin
                    // Completion takes priority over a same-cycle abort
                    w_done_set      = 1'b1;
                    w_next_state    = IDLE;
                    w_byte_cnt_next = 4'h0;
                    w_to_cnt_next   = 8'h00;
                end else if (bus.abort_p) begin
                    w_flush         = 1'b1;
                    w_next_state    = IDLE;
                    w_byte_cnt_next = 4'h0;
                    w_to_cnt_next   = 8'h00;
                end else begin
                    w_ps_ready = w_room & ~w_all_loaded;
                    if (w_ps_ready && bus.psBitmapValid) begin
                        w_load          = 1'b1;
                        w_load_data     = bus.psBitmap;
                        w_load_last     = (r_byte_cnt == C_BB_LAST);
                        w_byte_cnt_next = r_byte_cnt + 4'h1;
                        w_to_cnt_next   = 8'h00;
                    end else if (w_ps_ready) begin
                        if (r_to_cnt == C_TO_LAST) begin
                            w_error_set     = 1'b1;
                            w_flush         = 1'b1;
                            w_next_state    = IDLE;
                            w_byte_cnt_next = 4'h0;
                            w_to_cnt_next   = 8'h00;
                        end else begin
                            w_to_cnt_next = r_to_cnt + 8'h01;
                        end
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign bus.psBitmapReady = w_ps_ready;
    assign bus.txByte        = w_out_data;
    assign bus.txByteValid   = w_out_valid;
    assign bus.txByteLast    = w_out_last;
    assign bus.baBodyDone_p  = r_done;
    assign bus.baBodyError_p = r_error;
    assign bus.busy          = (r_state != IDLE);

endmodule
`default_nettype wire
